c_bus_writeback: RTL
====================

Name: c_bus_writeback

Overview:
- Write-back end of the datapath. Takes the 24-bit C bus from the ALU and a destination code, and loads the value into the selected register at the clock edge.
- Holds the architectural registers that the B-bus source selector reads: MDR, PC, MBRU, R1, R2, R3, R4 and R. It also holds MAR.
- Also handles the PC auto-increment and the memory-side loads of MDR and MBRU.
- Sits between the ALU output and the B-bus source selector.

Parameters:
GPRWIDTH, 24, width of C bus and general registers R1–R4, R
PCWIDTH, 9, width of PC and MAR
BYTEWIDTH, 8, width of MDR and MBRU
CONTROLBITS, 4, width of destination code

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
C_bus  input  GPRWIDTH  write-back data from ALU
c_control  input  CONTROLBITS  destination code
c_write  input  1  write strobe; c_control sampled only when high
pc_inc  input  1  increment PC by 1
mem_load  input  1  load MDR from mem_data
mbru_load  input  1  load MBRU from mem_data
mem_data  input  BYTEWIDTH  byte from memory
MAR  output  PCWIDTH  memory address register
MDR  output  BYTEWIDTH  memory data register
PC  output  PCWIDTH  program counter
MBRU  output  BYTEWIDTH  instruction byte register
R1, R2, R3, R4, R  output  GPRWIDTH each  general registers
wr_ack  output  1  one-cycle pulse: a legal c_write was committed
bad_dest  output  1  one-cycle pulse: c_write with an illegal code
collision  output  1  one-cycle pulse: C-bus write and mem_load both targeted MDR in the same cycle

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low. When rst_n=0 at a rising edge, all registers and flags go to 0, and all other inputs are ignored that cycle.
- Registered outputs: every output is a register, so the value is visible in the cycle after the edge that loads it.
- Write latency: one edge from c_write to the new register value. wr_ack is high in the same cycle the new value appears.
- Destination codes (valid only when c_write=1):
  - 0 → MDR gets C_bus[7:0]
  - 1 → PC gets C_bus[8:0]
  - 2 → MAR gets C_bus[8:0] (MBRU is not C-bus writable, so code 2 targets MAR)
  - 3 → R1
  - 4 → R2
  - 5 → R3
  - 6 → R4
  - 7 → R (R1–R4 and R take full C_bus)
  - 8–15 → illegal: no register changes, bad_dest=1 next cycle, wr_ack=0
- Width rule: narrow destinations take the low bits of C_bus; upper bits are discarded silently. No sign extension.
- PC priority: a C-bus write to PC (code 1) overrides pc_inc in the same cycle, so the loaded value is not incremented. Otherwise pc_inc makes PC = PC+1 mod 2^PCWIDTH, so 511 wraps to 0.
- MDR priority: a C-bus write to MDR (code 0) overrides mem_load. In that case collision=1 next cycle and the memory byte is dropped. mem_load alone makes MDR = mem_data.
- MBRU: written only by mbru_load. It can load in the same cycle as any C-bus write.
- Concurrency: a C-bus write to a non-PC, non-MDR register proceeds in parallel with pc_inc, mem_load and mbru_load. Exactly one C-bus destination is written per cycle.
- c_write=0: c_control is don't-care. No flags are raised. Registers hold unless pc_inc, mem_load or mbru_load is asserted.
- Flag timing: wr_ack, bad_dest and collision are single-cycle pulses and are 0 in any cycle without a qualifying event. wr_ack and collision can both be 1 at once. bad_dest excludes wr_ack.
- Reset mid-operation: rst_n=0 dominates every concurrent write, increment and load. Pulses do not carry across reset.

Test Plan:
- Reset clears state: preload R1=24'hABCDEF, PC=9'h1FF, then rst_n=0 for one edge → all outputs 0, wr_ack=0.
- Sweep legal codes: c_write=1 with C_bus=24'h123456 for codes 0..7 in turn → MDR=8'h56, PC=9'h056, MAR=9'h056, R1..R4 and R=24'h123456. wr_ack pulses each cycle. MBRU stays 0.
- PC rules: PC=9'h1FF plus pc_inc → PC=0. Next, pc_inc and c_write code 1 with C_bus=24'h000010 in the same cycle → PC=9'h010, not 9'h011.
- MDR collision: mem_load=1, mem_data=8'h77, c_write code 0, C_bus=24'h0000AA → MDR=8'hAA, collision=1, wr_ack=1. Next cycle mem_load alone → MDR=8'h77, collision=0.
- Illegal code: c_write=1, c_control=4'd9, C_bus=24'hFFFFFF → no register changes, bad_dest=1 for exactly one cycle, wr_ack=0.
- Parallel update: c_write code 5 with C_bus=24'h00BEEF, plus mbru_load with mem_data=8'h3C and pc_inc from PC=9'h004, all in one cycle → R3=24'h00BEEF, MBRU=8'h3C, PC=9'h005.

Source files
------------

// File: rtl/c_bus_writeback.sv
// Write-back stage: commits the ALU C bus into the selected architectural register and
// also handles the PC auto-increment and the memory-side MDR/MBRU loads.
module c_bus_writeback #(
    parameter int unsigned GPRWIDTH    = 24,
    parameter int unsigned PCWIDTH     = 9,
    parameter int unsigned BYTEWIDTH   = 8,
    parameter int unsigned CONTROLBITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [GPRWIDTH-1:0]    C_bus,
    input  logic [CONTROLBITS-1:0] c_control,
    input  logic                   c_write,
    input  logic                   pc_inc,
    input  logic                   mem_load,
    input  logic                   mbru_load,
    input  logic [BYTEWIDTH-1:0]   mem_data,
    output logic [PCWIDTH-1:0]     MAR,
    output logic [BYTEWIDTH-1:0]   MDR,
    output logic [PCWIDTH-1:0]     PC,
    output logic [BYTEWIDTH-1:0]   MBRU,
    output logic [GPRWIDTH-1:0]    R1,
    output logic [GPRWIDTH-1:0]    R2,
    output logic [GPRWIDTH-1:0]    R3,
    output logic [GPRWIDTH-1:0]    R4,
    output logic [GPRWIDTH-1:0]    R,
    output logic                   wr_ack,
    output logic                   bad_dest,
    output logic                   collision
);

    typedef enum logic [CONTROLBITS-1:0] {
        DstMdr = 4'd0,
        DstPc  = 4'd1,
        DstMar = 4'd2,
        DstR1  = 4'd3,
        DstR2  = 4'd4,
        DstR3  = 4'd5,
        DstR4  = 4'd6,
        DstR   = 4'd7
    } dest_e;

    logic [PCWIDTH-1:0]   r_mar, r_pc;
    logic [BYTEWIDTH-1:0] r_mdr, r_mbru;
    logic [GPRWIDTH-1:0]  r_r1, r_r2, r_r3, r_r4, r_r;
    logic                 r_wr_ack, r_bad_dest, r_collision;

    logic [PCWIDTH-1:0]   w_mar_d, w_pc_d;
    logic [BYTEWIDTH-1:0] w_mdr_d, w_mbru_d;
    logic [GPRWIDTH-1:0]  w_r1_d, w_r2_d, w_r3_d, w_r4_d, w_r_d;
    logic                 w_wr_ack_d, w_bad_dest_d, w_collision_d;

    logic                 w_legal;
    logic [7:0]           w_sel;

    // Codes 8..15 have the top bit set; only the low three bits select a register.
    assign w_legal = c_write && !c_control[CONTROLBITS-1];

    always_comb begin
        w_sel = 8'b0;
        if (w_legal) begin
            unique case (dest_e'(c_control))
                DstMdr:  w_sel[0] = 1'b1;
                DstPc:   w_sel[1] = 1'b1;
                DstMar:  w_sel[2] = 1'b1;
                DstR1:   w_sel[3] = 1'b1;
                DstR2:   w_sel[4] = 1'b1;
                DstR3:   w_sel[5] = 1'b1;
                DstR4:   w_sel[6] = 1'b1;
                DstR:    w_sel[7] = 1'b1;
                default: w_sel    = 8'b0;
            endcase
        end
    end

    always_comb begin
        w_mar_d       = r_mar;
        w_pc_d        = r_pc;
        w_mdr_d       = r_mdr;
        w_mbru_d      = r_mbru;
        w_r1_d        = r_r1;
        w_r2_d        = r_r2;
        w_r3_d        = r_r3;
        w_r4_d        = r_r4;
        w_r_d         = r_r;
        w_wr_ack_d    = w_legal;
        w_bad_dest_d  = c_write && !w_legal;
        w_collision_d = w_sel[0] && mem_load;

        // A C-bus write takes precedence over the memory byte and the increment.
        if (w_sel[0]) begin
            w_mdr_d = C_bus[BYTEWIDTH-1:0];
        end else if (mem_load) begin
            w_mdr_d = mem_data;
        end

        if (w_sel[1]) begin
            w_pc_d = C_bus[PCWIDTH-1:0];
        end else if (pc_inc) begin
            w_pc_d = r_pc + PCWIDTH'(1);
        end

        if (w_sel[2]) w_mar_d = C_bus[PCWIDTH-1:0];
        if (w_sel[3]) w_r1_d  = C_bus;
        if (w_sel[4]) w_r2_d  = C_bus;
        if (w_sel[5]) w_r3_d  = C_bus;
        if (w_sel[6]) w_r4_d  = C_bus;
        if (w_sel[7]) w_r_d   = C_bus;

        if (mbru_load) w_mbru_d = mem_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mar       <= '0;
            r_pc        <= '0;
            r_mdr       <= '0;
            r_mbru      <= '0;
            r_r1        <= '0;
            r_r2        <= '0;
            r_r3        <= '0;
            r_r4        <= '0;
            r_r         <= '0;
            r_wr_ack    <= 1'b0;
            r_bad_dest  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_mar       <= w_mar_d;
            r_pc        <= w_pc_d;
            r_mdr       <= w_mdr_d;
            r_mbru      <= w_mbru_d;
            r_r1        <= w_r1_d;
            r_r2        <= w_r2_d;
            r_r3        <= w_r3_d;
            r_r4        <= w_r4_d;
            r_r         <= w_r_d;
            r_wr_ack    <= w_wr_ack_d;
            r_bad_dest  <= w_bad_dest_d;
            r_collision <= w_collision_d;
        end
    end

    assign MAR       = r_mar;
    assign MDR       = r_mdr;
    assign PC        = r_pc;
    assign MBRU      = r_mbru;
    assign R1        = r_r1;
    assign R2        = r_r2;
    assign R3        = r_r3;
    assign R4        = r_r4;
    assign R         = r_r;
    assign wr_ack    = r_wr_ack;
    assign bad_dest  = r_bad_dest;
    assign collision = r_collision;

endmodule
